// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store bridge (lsu_mem_bridge and lsu_lane_align).
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_X = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_CAP,
        ST_WR,
        ST_RESP
    } state_e;

    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;
    localparam int HALF_SEL_BIT = 1;

    // Offset bits that must be zero for an access of the given size.
    localparam logic [1:0] HALF_MIS_MASK = 2'b01;
    localparam logic [1:0] WORD_MIS_MASK = 2'b11;

    function automatic logic misaligned(input size_e sz, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        case (sz)
            SZ_H:    bad = (off & HALF_MIS_MASK) != 2'b00;
            SZ_W:    bad = (off & WORD_MIS_MASK) != 2'b00;
            SZ_X:    bad = 1'b1;
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_mem_bridge_lane_align.sv
// Little-endian lane handling: load extract/extend and sub-word store merge (combinational).
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] ld_word,
    input  logic [1:0]        ld_off,
    input  size_e             ld_size,
    input  logic              ld_signed,
    output logic [DATA_W-1:0] ld_data,
    input  logic [DATA_W-1:0] st_old,
    input  logic [DATA_W-1:0] st_wdata,
    input  logic [1:0]        st_off,
    input  size_e             st_size,
    output logic [DATA_W-1:0] st_word
);

    logic [BYTE_W-1:0] lane_b;
    logic [HALF_W-1:0] lane_h;

    always_comb begin
        lane_b  = ld_word[{ld_off, 3'b000} +: BYTE_W];
        lane_h  = ld_word[{ld_off[HALF_SEL_BIT], 4'b0000} +: HALF_W];
        ld_data = ld_word;
        case (ld_size)
            SZ_B:    ld_data = {{(DATA_W-BYTE_W){ld_signed & lane_b[BYTE_W-1]}}, lane_b};
            SZ_H:    ld_data = {{(DATA_W-HALF_W){ld_signed & lane_h[HALF_W-1]}}, lane_h};
            default: ld_data = ld_word;
        endcase
    end

    always_comb begin
        st_word = st_old;
        case (st_size)
            SZ_B:    st_word[{st_off, 3'b000} +: BYTE_W] = st_wdata[BYTE_W-1:0];
            SZ_H:    st_word[{st_off[HALF_SEL_BIT], 4'b0000} +: HALF_W] = st_wdata[HALF_W-1:0];
            SZ_W:    st_word = st_wdata;
            default: st_word = st_old;
        endcase
    end

endmodule

// File: rtl/lsu_mem_bridge.sv
// Load/store bridge to a word-wide memory with read-modify-write for sub-word stores.
// Optional last-word buffer enabled by defining LSU_LAST_WORD_EN.
module lsu_mem_bridge
    import lsu_pkg::*;
#(
    parameter int MEM_RD_LAT = 1,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_R,
    output logic              mem_W,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam int CNT_W = (MEM_RD_LAT > 1) ? $clog2(MEM_RD_LAT) : 1;

    state_e              state_q, state_d;
    logic                we_q, we_d;
    size_e               size_q, size_d;
    logic                sgn_q, sgn_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   word_q, word_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    size_e               req_sz;
    logic                cap_done;
    logic                lw_hit;
    logic [DATA_W-1:0]   lw_word;
    logic [DATA_W-1:0]   ld_word, ld_data, st_word;
    logic [1:0]          ld_off;
    size_e               ld_size;
    logic                ld_sgn;

    assign req_sz   = size_e'(req_size);
    assign cap_done = (state_q == ST_CAP) && (cnt_q == '0);

    // In IDLE the extractor serves a buffer hit from the live request; otherwise the memory word.
    assign ld_word = (state_q == ST_IDLE) ? lw_word       : mem_dout;
    assign ld_off  = (state_q == ST_IDLE) ? req_addr[1:0] : addr_q[1:0];
    assign ld_size = (state_q == ST_IDLE) ? req_sz        : size_q;
    assign ld_sgn  = (state_q == ST_IDLE) ? req_signed    : sgn_q;

    lsu_lane_align #(.DATA_W(DATA_W)) u_align (
        .ld_word   (ld_word),
        .ld_off    (ld_off),
        .ld_size   (ld_size),
        .ld_signed (ld_sgn),
        .ld_data   (ld_data),
        .st_old    (word_q),
        .st_wdata  (wdata_q),
        .st_off    (addr_q[1:0]),
        .st_size   (size_q),
        .st_word   (st_word)
    );

    assign req_ready  = (state_q == ST_IDLE) && !reset;
    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign mem_R      = (state_q == ST_RD);
    assign mem_W      = (state_q == ST_WR);
    assign mem_addr   = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_din    = mem_W ? st_word : '0;

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        sgn_d   = sgn_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        word_d  = word_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_sz;
                    sgn_d   = req_signed;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    if (misaligned(req_sz, req_addr[1:0])) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else if (req_we) begin
                        if (req_sz == SZ_W) begin
                            state_d = ST_WR;
                        end else if (lw_hit) begin
                            word_d  = lw_word;
                            state_d = ST_WR;
                        end else begin
                            state_d = ST_RD;
                        end
                    end else if (lw_hit) begin
                        rdata_d = ld_data;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: begin
                cnt_d   = CNT_W'(MEM_RD_LAT - 1);
                state_d = ST_CAP;
            end
            ST_CAP: begin
                if (cap_done) begin
                    word_d = mem_dout;
                    if (we_q) begin
                        state_d = ST_WR;
                    end else begin
                        rdata_d = ld_data;
                        state_d = ST_RESP;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_WR:   state_d = ST_RESP;
            ST_RESP: if (resp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            size_q  <= SZ_B;
            sgn_q   <= 1'b0;
            addr_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            sgn_q   <= sgn_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Data-only registers; their outputs are gated by state so they need no reset.
    always_ff @(posedge clk) begin
        wdata_q <= wdata_d;
        word_q  <= word_d;
    end

`ifdef LSU_LAST_WORD_EN
    logic                lw_valid_q, lw_valid_d;
    logic [ADDR_W-3:0]   lw_addr_q, lw_addr_d;
    logic [DATA_W-1:0]   lw_data_q, lw_data_d;

    always_comb begin
        lw_valid_d = lw_valid_q;
        lw_addr_d  = lw_addr_q;
        lw_data_d  = lw_data_q;
        if (cap_done) begin
            lw_valid_d = 1'b1;
            lw_addr_d  = addr_q[ADDR_W-1:2];
            lw_data_d  = mem_dout;
        end else if (state_q == ST_WR) begin
            lw_valid_d = 1'b1;
            lw_addr_d  = addr_q[ADDR_W-1:2];
            lw_data_d  = st_word;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) lw_valid_q <= 1'b0;
        else       lw_valid_q <= lw_valid_d;
    end

    always_ff @(posedge clk) begin
        lw_addr_q <= lw_addr_d;
        lw_data_q <= lw_data_d;
    end

    assign lw_hit  = lw_valid_q && (lw_addr_q == req_addr[ADDR_W-1:2]);
    assign lw_word = lw_data_q;
`else
    assign lw_hit  = 1'b0;
    assign lw_word = '0;
`endif

endmodule

// File: tb/tb_lsu_mem_bridge.sv
// Directed, table-driven bench for lsu_mem_bridge with a 1-cycle registered memory model.
module tb_lsu_mem_bridge;

    logic        clk, reset;
    logic        req_valid, req_ready, req_we, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_R, mem_W;
    logic [31:0] mem_addr, mem_din, mem_dout;

`ifdef LSU_LAST_WORD_EN
    localparam bit LW = 1'b1;
`else
    localparam bit LW = 1'b0;
`endif

    lsu_mem_bridge #(.MEM_RD_LAT(1), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_R(mem_R), .mem_W(mem_W),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [0:255];
    logic        pre_en;
    logic [7:0]  pre_idx;
    logic [31:0] pre_val;

    always @(posedge clk) begin
        if (pre_en) mem[pre_idx] <= pre_val;
        if (mem_W)  mem[mem_addr[9:2]] <= mem_din;
        if (mem_R)  mem_dout <= mem[mem_addr[9:2]];
    end

    int          n_r = 0, n_w = 0, both_hi = 0;
    logic [31:0] last_din = '0, last_waddr = '0;

    always @(posedge clk) begin
        if (mem_R) n_r++;
        if (mem_W) begin
            n_w++;
            last_din   = mem_din;
            last_waddr = mem_addr;
        end
        if (mem_R && mem_W) both_hi++;
    end

    int n_checks = 0, n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        pre;
        logic [31:0] pre_val;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          nr;
        int          nw;
        logic [31:0] din;
        logic        hit;
    } vec_t;

    function automatic vec_t mk(logic we, logic [1:0] sz, logic sg, logic [31:0] a,
                                logic [31:0] wd, logic pre, logic [31:0] pv,
                                logic [31:0] rd, logic er, int lat, int nr, int nw,
                                logic [31:0] din, logic hit);
        vec_t v;
        v.we = we; v.size = sz; v.sgn = sg; v.addr = a; v.wdata = wd;
        v.pre = pre; v.pre_val = pv; v.rdata = rd; v.err = er;
        v.lat = lat; v.nr = nr; v.nw = nw; v.din = din; v.hit = hit;
        return v;
    endfunction

    vec_t vecs [16];

    task automatic run_req(input int id, input vec_t v);
        int lat, br, bw, exp_lat, exp_nr;
        if (v.pre) begin
            @(negedge clk);
            pre_en = 1'b1; pre_idx = v.addr[9:2]; pre_val = v.pre_val;
        end
        @(negedge clk);
        pre_en  = 1'b0;
        exp_lat = v.lat;
        exp_nr  = v.nr;
        if (LW && v.hit) begin
            exp_lat = v.we ? 2 : 1;
            exp_nr  = 0;
        end
        chk($sformatf("v%0d.req_ready", id), {31'b0, req_ready}, 32'd1);
        br = n_r; bw = n_w;
        req_valid = 1'b1; req_we = v.we; req_size = v.size; req_signed = v.sgn;
        req_addr = v.addr; req_wdata = v.wdata;
        lat = 0;
        do begin
            @(posedge clk); #1;
            req_valid = 1'b0;
            lat++;
        end while (!resp_valid && lat < 20);
        chk($sformatf("v%0d.latency", id), 32'(lat), 32'(exp_lat));
        chk($sformatf("v%0d.rdata", id), resp_rdata, v.rdata);
        chk($sformatf("v%0d.err", id), {31'b0, resp_err}, {31'b0, v.err});
        chk($sformatf("v%0d.mem_R_count", id), 32'(n_r - br), 32'(exp_nr));
        chk($sformatf("v%0d.mem_W_count", id), 32'(n_w - bw), 32'(v.nw));
        if (v.nw != 0) begin
            chk($sformatf("v%0d.mem_din", id), last_din, v.din);
            chk($sformatf("v%0d.mem_addr", id), last_waddr, {v.addr[31:2], 2'b00});
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk($sformatf("v%0d.resp_drop", id), {31'b0, resp_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, bw;
        logic seen;
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        pre_en = 1'b0; pre_idx = '0; pre_val = '0;

        //             we sz     sg addr          wdata         pre pre_val       rdata         er lat nr nw din           hit
        vecs[0]  = mk(1, 2'b00, 0, 32'h00400005, 32'h123456AB, 1, 32'h11223344, 32'h00000000, 0, 4, 1, 1, 32'h1122AB44, 0);
        vecs[1]  = mk(1, 2'b10, 0, 32'h00400000, 32'h00100413, 0, 32'h0,        32'h00000000, 0, 2, 0, 1, 32'h00100413, 0);
        vecs[2]  = mk(0, 2'b10, 0, 32'h00400000, 32'hDEADBEEF, 0, 32'h0,        32'h00100413, 0, 3, 1, 0, 32'h0,        1);
        vecs[3]  = mk(0, 2'b00, 1, 32'h00400007, 32'hDEADBEEF, 1, 32'h80FF7F01, 32'hFFFFFF80, 0, 3, 1, 0, 32'h0,        0);
        vecs[4]  = mk(0, 2'b00, 0, 32'h00400006, 32'hDEADBEEF, 0, 32'h0,        32'h000000FF, 0, 3, 1, 0, 32'h0,        1);
        vecs[5]  = mk(0, 2'b01, 1, 32'h00400004, 32'hDEADBEEF, 0, 32'h0,        32'h00007F01, 0, 3, 1, 0, 32'h0,        1);
        vecs[6]  = mk(0, 2'b01, 1, 32'h00400006, 32'hDEADBEEF, 0, 32'h0,        32'hFFFF80FF, 0, 3, 1, 0, 32'h0,        1);
        vecs[7]  = mk(0, 2'b01, 0, 32'h00400006, 32'hDEADBEEF, 0, 32'h0,        32'h000080FF, 0, 3, 1, 0, 32'h0,        1);
        vecs[8]  = mk(0, 2'b10, 1, 32'h00400004, 32'hDEADBEEF, 0, 32'h0,        32'h80FF7F01, 0, 3, 1, 0, 32'h0,        1);
        vecs[9]  = mk(0, 2'b10, 0, 32'h00400002, 32'hDEADBEEF, 0, 32'h0,        32'h00000000, 1, 1, 0, 0, 32'h0,        0);
        vecs[10] = mk(0, 2'b11, 0, 32'h00400000, 32'hDEADBEEF, 0, 32'h0,        32'h00000000, 1, 1, 0, 0, 32'h0,        0);
        vecs[11] = mk(1, 2'b01, 0, 32'h00400001, 32'hCAFEBEEF, 0, 32'h0,        32'h00000000, 1, 1, 0, 0, 32'h0,        0);
        vecs[12] = mk(1, 2'b01, 0, 32'h00400006, 32'hCAFEBEEF, 0, 32'h0,        32'h00000000, 0, 4, 1, 1, 32'hBEEF7F01, 1);
        vecs[13] = mk(0, 2'b00, 1, 32'h00400004, 32'hDEADBEEF, 0, 32'h0,        32'h00000001, 0, 3, 1, 0, 32'h0,        1);
        vecs[14] = mk(1, 2'b00, 0, 32'h00400000, 32'hFFFFFF5A, 0, 32'h0,        32'h00000000, 0, 4, 1, 1, 32'h0010045A, 0);
        vecs[15] = mk(0, 2'b00, 0, 32'h00400001, 32'hDEADBEEF, 0, 32'h0,        32'h00000004, 0, 3, 1, 0, 32'h0,        1);

        repeat (3) @(posedge clk);
        #1;
        chk("rst.req_ready", {31'b0, req_ready}, 32'd0);
        chk("rst.resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst.resp_err", {31'b0, resp_err}, 32'd0);
        chk("rst.resp_rdata", resp_rdata, 32'd0);
        chk("rst.mem_R", {31'b0, mem_R}, 32'd0);
        chk("rst.mem_W", {31'b0, mem_W}, 32'd0);
        chk("rst.mem_addr", mem_addr, 32'd0);
        chk("rst.mem_din", mem_din, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) run_req(i, vecs[i]);

        // Response back-pressure with an ignored request pulse.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h00400007; req_wdata = 32'h0;
        lat = 0;
        do begin
            @(posedge clk); #1;
            req_valid = 1'b0;
            lat++;
        end while (!resp_valid && lat < 20);
        chk("bp.latency", 32'(lat), 32'd3);
        bw = n_w;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10;
                req_addr = 32'h00400040; req_wdata = 32'h55555555;
            end else begin
                req_valid = 1'b0;
            end
            @(posedge clk); #1;
            chk($sformatf("bp%0d.resp_valid", k), {31'b0, resp_valid}, 32'd1);
            chk($sformatf("bp%0d.resp_rdata", k), resp_rdata, 32'h000000BE);
            chk($sformatf("bp%0d.req_ready", k), {31'b0, req_ready}, 32'd0);
        end
        @(negedge clk);
        req_valid = 1'b0; resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk($sformatf("bp.after%0d.resp_valid", k), {31'b0, resp_valid}, 32'd0);
        end
        chk("bp.no_write", 32'(n_w - bw), 32'd0);
        chk("bp.req_ready", {31'b0, req_ready}, 32'd1);

        // Reset in the middle of a sub-word store's write cycle.
        @(negedge clk);
        pre_en = 1'b1; pre_idx = 8'd4; pre_val = 32'hAABBCCDD;
        @(negedge clk);
        pre_en = 1'b0;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h00400011; req_wdata = 32'h00000011;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(posedge clk); #1;
            req_valid = 1'b0;
            seen = mem_W;
        end
        chk("rstwr.mem_W_seen", {31'b0, seen}, 32'd1);
        reset = 1'b1;
        #1;
        chk("rstwr.mem_W", {31'b0, mem_W}, 32'd0);
        chk("rstwr.mem_din", mem_din, 32'd0);
        chk("rstwr.resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rstwr.req_ready", {31'b0, req_ready}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rstwr.req_ready_after", {31'b0, req_ready}, 32'd1);
        chk("rstwr.resp_valid_after", {31'b0, resp_valid}, 32'd0);
        run_req(100, mk(0, 2'b10, 0, 32'h00400010, 32'h0, 0, 32'h0, 32'hAABBCCDD, 0, 3, 1, 0, 32'h0, 0));

        chk("strobe_overlap", 32'(both_hi), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_mem_bridge.md
Name: lsu_mem_bridge

Overview:
Load/store unit sitting directly upstream of the word-wide simulation memory (R/W strobes, 32-bit address, 1-cycle registered read data). Accepts byte/half/word load and store requests from the core over a valid/ready handshake. Converts them into word-aligned memory accesses, performing read-modify-write for sub-word stores. Returns sign- or zero-extended load data and a misalignment error on a held response channel.

Parameters:
MEM_RD_LAT, 1, cycles between the mem_R-asserting cycle and the edge at which mem_dout is valid to capture (>=1)
ADDR_W, 32, byte address width
DATA_W, 32, word width (fixed at 32; other values unsupported)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req_valid  in  1  core request valid
req_ready  out  1  bridge can accept a request
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_signed  in  1  sign-extend load result
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  store data, right-justified
resp_valid  out  1  response available
resp_ready  in  1  core consumes response
resp_rdata  out  DATA_W  extended load data (0 for stores/errors)
resp_err  out  1  misaligned or illegal-size request
mem_R  out  1  memory read strobe
mem_W  out  1  memory write strobe
mem_addr  out  ADDR_W  word address = {req_addr[ADDR_W-1:2], 2'b00}
mem_din  out  DATA_W  write data to memory
mem_dout  in  DATA_W  read data from memory

Behaviour:
- Reset (async): state IDLE; resp_valid, resp_err, mem_R, mem_W = 0; resp_rdata, mem_addr, mem_din = 0; req_ready = 0 while reset high. An in-flight request and its pending response are discarded.
- req_ready = 1 only in IDLE. Handshake on posedge with req_valid & req_ready; all request fields are registered at that edge.
- States: IDLE, RD, CAP, WR, RESP.
- Error check at accept: half with addr[0]=1, word with addr[1:0]!=0, or size=11 -> IDLE->RESP, resp_err=1, resp_rdata=0, no memory strobe.
- Load: IDLE->RD->CAP->RESP. RD holds mem_R=1 for exactly 1 cycle. CAP waits MEM_RD_LAT cycles, then captures mem_dout at the edge ending CAP.
- Word store: IDLE->WR->RESP. WR drives mem_W=1 for exactly 1 cycle with mem_din=req_wdata.
- Sub-word store: IDLE->RD->CAP->WR->RESP. The captured word is merged with the store lanes and the merged word is written.
- Lanes are little-endian: byte k = word[8k+7:8k], k = addr[1:0]; half at addr[1]*16.
- Load extract: selected lane right-justified; bits above it filled with lane MSB if req_signed, else 0. Word loads ignore req_signed.
- RESP: resp_valid=1, resp_rdata/resp_err stable until the resp_ready edge, then IDLE. No new request accepted in the same edge (req_ready is low in RESP).
- Latency at MEM_RD_LAT=1, measured to resp_valid high after the accept edge: load 3 cycles, word store 2, sub-word store 4, error 1.
- mem_R and mem_W are never high together; mem_addr is held constant across RD/CAP/WR of one request.

Optional Feature:
LSU_LAST_WORD_EN. When defined, a 1-entry buffer holds {valid, word address, data} of the last word read from or written to memory; valid is cleared on reset.
- Load hit: IDLE->RESP with buffered data (latency 1).
- Sub-word store hit: skips RD/CAP (IDLE->WR->RESP).
- Every WR updates the buffer with the merged data.
When undefined: no buffer exists, and every access follows the base state paths.

Decomposition:
- Package lsu_pkg: size enum (SZ_B, SZ_H, SZ_W, SZ_X), state enum, lane-select and misalign constants.
- Sub-module lsu_lane_align, purely combinational:
  - load extract/extend (word, addr[1:0], size, signed -> rdata)
  - store merge (old word, wdata, addr[1:0], size -> new word)

Test Plan:
- Word store 0x00400000 <- 0x00100413, then word load of same address -> mem_W one cycle with mem_addr=0x00400000; load resp_rdata=0x00100413 exactly 3 cycles after accept, resp_err=0.
- Memory word 0x80FF7F01 at 0x00400004:
  - signed byte load of 0x00400007 -> 0xFFFFFF80
  - unsigned byte load of 0x00400006 -> 0x000000FF
  - signed half load of 0x00400004 -> 0x00007F01
- Byte store 0xAB to 0x00400005 over word 0x11223344 -> RD then WR, mem_din=0x1122AB44, resp at cycle 4.
- Word load at 0x00400002, and size=11 -> resp_err=1, resp_rdata=0, mem_R/mem_W never asserted, resp in 1 cycle.
- resp_ready held low 5 cycles -> resp_valid/resp_rdata stable, req_ready=0; a req_valid pulse during this time is not accepted.
- reset asserted during WR of a sub-word store -> mem_W drops immediately, resp_valid=0, req_ready=1 on the first edge after release. With LSU_LAST_WORD_EN, the following load of the same address issues mem_R (buffer invalidated).
